// File: rtl/sap_pkg.sv
// Shared SAP-1 microsequencer definitions: opcodes,
// named control words and the sequencer state encodings.
package sap_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
   localparam logic [11:0] CW_FETCH_T1 = 12'h5E3;
   localparam logic [11:0] CW_FETCH_T2 = 12'hBE3;
   localparam logic [11:0] CW_FETCH_T3 = 12'h263;
   localparam logic [11:0] CW_IR_TO_MAR = 12'h1A3;
   localparam logic [11:0] CW_LDA_T5 = 12'h2C3;
   localparam logic [11:0] CW_ALU_T5 = 12'h2E1;
   localparam logic [11:0] CW_ADD_T6 = 12'h3C7;
   localparam logic [11:0] CW_SUB_T6 = 12'h3CF;
   localparam logic [11:0] CW_OUT_T4 = 12'h3F2;
   localparam logic [11:0] CW_IDLE = 12'h3E3;

   typedef enum logic [2:0] {
      S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_WAIT, S_HALT
   } state_t;

   // Run/park mode kept beside the T-state ring.
   typedef enum logic [1:0] {
      M_RUN, M_WAIT, M_HALT
   } mode_t;

endpackage

// File: rtl/sap_ring_counter.sv
// Six-bit one-hot T-state ring (bit0 = T1).
// Ports: clock, reset (async low), advance, clear (to T1), hold; ring out.
module sap_ring_counter (
   input  logic       clock,
   input  logic       reset,
   input  logic       advance,
   input  logic       clear,
   input  logic       hold,
   output logic [5:0] ring
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ring <= 6'b000001;
      end else if (clear) begin
         ring <= 6'b000001;
      end else if (!hold && advance) begin
         ring <= {ring[4:0], ring[5]};
      end
   end

endmodule

// File: rtl/sap_microsequencer.sv
// SAP-1 control sequencer: T-state ring, step/halt mode and control-word decode.
// Ports: clock, reset (async low), instruction, step_mode, step;
//        control_word, t_state, halted, instr_done.
module sap_microsequencer
   import sap_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  instruction,
   input  logic        step_mode,
   input  logic        step,
   output logic [11:0] control_word,
   output logic [5:0]  t_state,
   output logic        halted,
   output logic        instr_done
);

   mode_t      mode_q;
   mode_t      mode_n;
   state_t     state;
   logic [5:0] ring;
   logic       advance;
   logic       clear;
   logic       hold;
   logic       done_q;

   sap_ring_counter u_ring (
      .clock   (clock),
      .reset   (reset),
      .advance (advance),
      .clear   (clear),
      .hold    (hold),
      .ring    (ring)
   );

   // While parked the ring holds its last T-state; the mode masks it.
   always_comb begin
      state = S_T1;
      if (mode_q == M_HALT) begin
         state = S_HALT;
      end else if (mode_q == M_WAIT) begin
         state = S_WAIT;
      end else begin
         unique case (1'b1)
            ring[0]: state = S_T1;
            ring[1]: state = S_T2;
            ring[2]: state = S_T3;
            ring[3]: state = S_T4;
            ring[4]: state = S_T5;
            ring[5]: state = S_T6;
            default: state = S_T1;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mode_q <= M_RUN;
         done_q <= 1'b0;
      end else begin
         mode_q <= mode_n;
         done_q <= (state == S_T6);
      end
   end

   always_comb begin
      mode_n  = mode_q;
      advance = 1'b0;
      clear   = 1'b0;
      hold    = 1'b0;
      unique case (state)
         S_T4: begin
            if (instruction == OP_HLT) begin
               mode_n = M_HALT;
               hold   = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         S_T6: begin
            if (step_mode) begin
               mode_n = M_WAIT;
               hold   = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         S_WAIT: begin
            if (step || !step_mode) begin
               mode_n = M_RUN;
               clear  = 1'b1;
            end else begin
               hold = 1'b1;
            end
         end
         S_HALT: hold = 1'b1;
         default: advance = 1'b1;
      endcase
   end

   always_comb begin
      control_word = CW_IDLE;
      case (state)
         S_T1: control_word = CW_FETCH_T1;
         S_T2: control_word = CW_FETCH_T2;
         S_T3: control_word = CW_FETCH_T3;
         S_T4: begin
            case (instruction)
               OP_LDA, OP_ADD, OP_SUB: control_word = CW_IR_TO_MAR;
               OP_OUT: control_word = CW_OUT_T4;
               default: control_word = CW_IDLE;
            endcase
         end
         S_T5: begin
            case (instruction)
               OP_LDA: control_word = CW_LDA_T5;
               OP_ADD, OP_SUB: control_word = CW_ALU_T5;
               default: control_word = CW_IDLE;
            endcase
         end
         S_T6: begin
            case (instruction)
               OP_ADD: control_word = CW_ADD_T6;
               OP_SUB: control_word = CW_SUB_T6;
               default: control_word = CW_IDLE;
            endcase
         end
         default: control_word = CW_IDLE;
      endcase
   end

   assign t_state    = (mode_q == M_RUN) ? ring : 6'b000000;
   assign halted     = (mode_q == M_HALT);
   assign instr_done = done_q;

endmodule
